// File: rtl/seq_div_pkg.sv
// Shared types and default widths for the sequential 10-by-5 restoring divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seq_div_pkg;

    // Default dividend/quotient and divisor/remainder widths
    localparam int DIVIDEND_W_DFLT = 10;
    localparam int DIVISOR_W_DFLT  = 5;

    // Iteration counter width, enough to count DIVIDEND_W steps
    localparam int CNT_W = $clog2(DIVIDEND_W_DFLT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_10by5_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module div_step #(
    parameter int DIVISOR_W = 5
) (
    input  logic [DIVISOR_W:0]   pr,
    input  logic                 msb,
    input  logic [DIVISOR_W-1:0] b,
    output logic [DIVISOR_W:0]   pr_next,
    output logic                 q_bit
);

    logic [DIVISOR_W:0] shifted;
    logic [DIVISOR_W:0] b_ext;
    logic               unused_pr_msb;

    // The partial remainder is always below the divisor between steps, so its
    // top bit is zero and only the low DIVISOR_W bits carry into the shift.
    assign unused_pr_msb = pr[DIVISOR_W];
    assign shifted       = {pr[DIVISOR_W-1:0], msb};
    assign b_ext         = {1'b0, b};

    // Trial subtraction; a zero divisor always "fits", giving an all-ones quotient
    always_comb begin
        pr_next = shifted;
        q_bit   = 1'b0;
        if (shifted >= b_ext) begin
            pr_next = shifted - b_ext;
            q_bit   = 1'b1;
        end
    end

endmodule

// File: rtl/seq_divider_10by5.sv
// Iterative restoring divider P/B -> Q,R (one quotient bit per clock); optional DIV_ZERO_FAST_EN.
// Latency: result valid 11 cycles after acceptance (1 cycle for B==0 when DIV_ZERO_FAST_EN is defined).
// Backpressure: result, dz and out_valid hold while out_ready is low; in_ready stays low until the result is taken.
module seq_divider_10by5
    import seq_div_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DFLT,
    parameter int DIVISOR_W  = DIVISOR_W_DFLT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] P,
    input  logic [DIVISOR_W-1:0]  B,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] Q,
    output logic [DIVISOR_W-1:0]  R,
    output logic                  dz
);

    state_t                state;
    // Dividend bits leave from the top while quotient bits enter at the bottom,
    // so after DIVIDEND_W steps this register holds the quotient.
    logic [DIVIDEND_W-1:0] dvd;
    logic [DIVISOR_W-1:0]  dsr;
    logic [DIVISOR_W:0]    pr;
    logic [DIVISOR_W:0]    pr_next;
    logic                  q_bit;
    logic [CNT_W-1:0]      cnt;

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_div_step (
        .pr      (pr),
        .msb     (dvd[DIVIDEND_W-1]),
        .b       (dsr),
        .pr_next (pr_next),
        .q_bit   (q_bit)
    );

    // Control FSM and datapath registers; all outputs are registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            Q         <= '0;
            R         <= '0;
            dz        <= 1'b0;
            cnt       <= '0;
            dvd       <= '0;
            dsr       <= '0;
            pr        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        dvd      <= P;
                        dsr      <= B;
                        pr       <= '0;
                        dz       <= (B == '0);
                        cnt      <= CNT_W'(DIVIDEND_W - 1);
                        in_ready <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
                        // Zero divisor: the iterative result is known up front
                        if (B == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            Q         <= '1;
                            R         <= P[DIVISOR_W-1:0];
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    dvd <= {dvd[DIVIDEND_W-2:0], q_bit};
                    pr  <= pr_next;
                    if (cnt == '0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        Q         <= {dvd[DIVIDEND_W-2:0], q_bit};
                        R         <= pr_next[DIVISOR_W-1:0];
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    // in_ready rises only after the handshake, never in the same cycle
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_10by5.sv
// Randomized and directed bench for seq_divider_10by5 against an arithmetic reference model.
// Latency: checks 11-cycle result latency (1 for zero divisor with DIV_ZERO_FAST_EN).
// Backpressure: holds out_ready low in DONE and checks output stability.
module tb_seq_divider_10by5;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] P;
    logic [4:0] B;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] Q;
    logic [4:0] R;
    logic       dz;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 11;
`endif

    seq_divider_10by5 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .P         (P),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .R         (R),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned division, with the fixed zero-divisor result
    function automatic void model(input int p, input int b,
                                  output int q, output int r, output int z, output int lat);
        if (b == 0) begin
            q   = 1023;
            r   = p % 32;
            z   = 1;
            lat = ZERO_LAT;
        end else begin
            q   = p / b;
            r   = p % b;
            z   = 0;
            lat = 11;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: offer, wait for result, optional stall, then consume
    task automatic run_op(input int p, input int b, input int hold, input bit poke);
        int q_e, r_e, z_e, lat_e, lat, w;
        model(p, b, q_e, r_e, z_e, lat_e);
        w = 0;
        while (!in_ready && w < 30) begin
            tick();
            w++;
        end
        check("ready_before_op", in_ready, 1);
        P        = p[9:0];
        B        = b[4:0];
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 40) begin
            if (poke) begin
                // Offer different operands while busy; they must be ignored
                in_valid = 1'b1;
                P        = 10'($urandom);
                B        = 5'($urandom);
                check("busy_in_ready", in_ready, 0);
            end
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check("latency", lat, lat_e);
        check("out_valid", out_valid, 1);
        check("quotient", Q, q_e);
        check("remainder", R, r_e);
        check("dz", dz, z_e);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_q", Q, q_e);
            check("hold_r", R, r_e);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t_acc[$];
        int w;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        P         = '0;
        B         = '0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_q", Q, 0);
        check("rst_r", R, 0);
        check("rst_dz", dz, 0);
        rst = 1'b0;
        tick();

        // Directed cases
        run_op(30, 5, 5, 1'b0);
        run_op(961, 31, 0, 1'b1);
        run_op(1023, 1, 0, 1'b0);
        run_op(0, 13, 0, 1'b0);
        run_op(100, 7, 2, 1'b1);
        run_op(500, 0, 3, 1'b0);

        // Back-to-back offers with the consumer always ready
        P         = 10'd200;
        B         = 5'd9;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (in_ready) t_acc.push_back(c);
            tick();
        end
        in_valid = 1'b0;
        if (t_acc.size() >= 2) check("b2b_interval", t_acc[1] - t_acc[0], 12);
        else check("b2b_accepts", t_acc.size(), 2);
        w = 0;
        while (!in_ready && w < 30) begin
            tick();
            w++;
        end
        out_ready = 1'b0;
        check("b2b_drain", in_ready, 1);

        // Reset in the middle of RUN discards the operation
        P        = 10'd700;
        B        = 5'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrun_in_ready", in_ready, 1);
        check("midrun_out_valid", out_valid, 0);
        check("midrun_q", Q, 0);
        check("midrun_r", R, 0);
        run_op(6, 3, 0, 1'b0);

        // Randomized operands, occasional zero divisor and stalls
        for (int n = 0; n < 25; n++) begin
            int p, b;
            p = int'($urandom_range(0, 1023));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31));
            run_op(p, b, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
